// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults plus the decode and popcount helpers for regfile_2r1w
package regfile_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NUM_REGS = 8;
    function automatic logic [31:0] addr_onehot(input logic [4:0] addr);
        return 32'h1 << addr;
    endfunction
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/regfile_entry.sv
// regfile_entry: one storage word with dirty flag; async active-low reset, sync clear over load
module regfile_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             dirty
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
            dirty <= 1'b0;
        end else if (clr) begin
            q <= '0;
            dirty <= 1'b0;
        end else if (ld) begin
            q <= d;
            dirty <= 1'b1;
        end
    end
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NUM_REGS x WIDTH register file, 1 sync write, 2 async reads, dirty tracking
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [WIDTH-1:0]    rd_data_a,
    output logic [WIDTH-1:0]    rd_data_b,
    output logic [NUM_REGS-1:0] dirty,
    output logic [ADDR_W:0]     wr_count
);
    logic [NUM_REGS-1:0] we;
    logic [WIDTH-1:0]    mem [NUM_REGS];

    // An unknown address yields an unknown load, which the entry's if() treats as no write
    assign we = NUM_REGS'(addr_onehot(5'(wr_addr))) & {NUM_REGS{wr_en}};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_ent
        regfile_entry #(.WIDTH(WIDTH)) u_ent (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clr),
            .ld      (we[i]),
            .d       (wr_data),
            .q       (mem[i]),
            .dirty   (dirty[i])
        );
    end

    assign wr_count = (ADDR_W + 1)'(popcount(32'(dirty)));

`ifdef REGFILE_BYPASS_EN
    logic byp_a, byp_b;
    assign byp_a = wr_en && !clr && (rd_addr_a == wr_addr);
    assign byp_b = wr_en && !clr && (rd_addr_b == wr_addr);
    assign rd_data_a = byp_a ? wr_data : mem[rd_addr_a];
    assign rd_data_b = byp_b ? wr_data : mem[rd_addr_b];
`else
    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];
`endif
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: table-driven scoreboard bench for regfile_2r1w (default and 32x32 instances)
module tb_regfile_2r1w;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en, clr;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wr_data, rd_data_a, rd_data_b;
    logic [7:0]  dirty;
    logic [3:0]  wr_count;

    logic        wr_en32, clr32;
    logic [4:0]  wr_addr32, rd_addr_a32, rd_addr_b32;
    logic [31:0] wr_data32, rd_data_a32, rd_data_b32, dirty32;
    logic [5:0]  wr_count32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_2r1w dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .dirty(dirty), .wr_count(wr_count)
    );

    regfile_2r1w #(.WIDTH(32), .NUM_REGS(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en32), .wr_addr(wr_addr32), .wr_data(wr_data32),
        .clr(clr32), .rd_addr_a(rd_addr_a32), .rd_addr_b(rd_addr_b32), .rd_data_a(rd_data_a32),
        .rd_data_b(rd_data_b32), .dirty(dirty32), .wr_count(wr_count32)
    );

    typedef struct {
        logic        we, cl;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra, rb;
        logic [15:0] ea, eb;
        logic [7:0]  ed;
        logic [3:0]  ec;
    } vec_t;

    typedef struct {
        logic [15:0] a, b;
        logic [7:0]  d;
        logic [3:0]  c;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(logic we, logic cl, logic [2:0] wa, logic [15:0] wd,
                                logic [2:0] ra, logic [2:0] rb, logic [15:0] ea,
                                logic [15:0] eb, logic [7:0] ed, logic [3:0] ec);
        vec_t v;
        v.we = we; v.cl = cl; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
        v.ea = ea; v.eb = eb; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        exp_t e;
        @(negedge clk);
        wr_en = v.we; clr = v.cl; wr_addr = v.wa; wr_data = v.wd;
        rd_addr_a = v.ra; rd_addr_b = v.rb;
        sb.push_back('{a: v.ea, b: v.eb, d: v.ed, c: v.ec});
        @(posedge clk);
        #1 wr_en = 1'b0; clr = 1'b0;
        #1;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, " rd_a"}, 32'(rd_data_a), 32'(e.a));
            check({tag, " rd_b"}, 32'(rd_data_b), 32'(e.b));
            check({tag, " dirty"}, 32'(dirty), 32'(e.d));
            check({tag, " count"}, 32'(wr_count), 32'(e.c));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; clr = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
        wr_en32 = 1'b0; clr32 = 1'b0; wr_addr32 = '0; wr_data32 = '0;
        rd_addr_a32 = '0; rd_addr_b32 = '0;

        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0, 3'(i), 16'h1000 + 16'(i), 3'(i), 3'(i), 16'h1000 + 16'(i),
                             16'h1000 + 16'(i), 8'((16'h1 << (i + 1)) - 1), 4'(i + 1)));
        tbl.push_back(mk(1, 1, 3'd5, 16'h1234, 3'd5, 3'd0, 16'h0, 16'h0, 8'h00, 4'd0));
        tbl.push_back(mk(1, 0, 3'd2, 16'h0005, 3'd2, 3'd2, 16'h0005, 16'h0005, 8'h04, 4'd1));
        tbl.push_back(mk(1, 0, 3'd2, 16'h00A0, 3'd0, 3'd2, 16'h0000, 16'h00A0, 8'h04, 4'd1));
        tbl.push_back(mk(1, 0, 3'd7, 16'hCAFE, 3'd7, 3'd2, 16'hCAFE, 16'h00A0, 8'h84, 4'd2));
        tbl.push_back(mk(0, 0, 3'd1, 16'hFFFF, 3'd0, 3'd7, 16'h0000, 16'hCAFE, 8'h84, 4'd2));

        repeat (2) @(posedge clk);
        #1;
        check("reset dirty", 32'(dirty), 32'h0);
        check("reset count", 32'(wr_count), 32'h0);
        check("reset rd_a", 32'(rd_data_a), 32'h0);
        @(negedge clk) reset_n = 1'b1;

        // Reset mid-operation, asserted between edges
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr_a = 3'd3;
        @(posedge clk);
        #1 wr_en = 1'b0;
        #1;
        check("beef rd_a", 32'(rd_data_a), 32'hBEEF);
        check("beef count", 32'(wr_count), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async rst rd_a", 32'(rd_data_a), 32'h0);
        check("async rst dirty", 32'(dirty), 32'h0);
        check("async rst count", 32'(wr_count), 32'h0);
        @(negedge clk);
        wr_en = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0;
        #1;
        check("no write in rst", 32'(rd_data_a), 32'h0);
        check("no dirty in rst", 32'(dirty), 32'h0);
        @(negedge clk) reset_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Same-address read during write, then clr suppressing any forwarding
        apply(mk(1, 0, 3'd4, 16'h0011, 3'd4, 3'd7, 16'h0011, 16'hCAFE, 8'h94, 4'd3), "r4");
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0022; rd_addr_a = 3'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same-cycle rd_a", 32'(rd_data_a), 32'h0022);
`else
        check("same-cycle rd_a", 32'(rd_data_a), 32'h0011);
`endif
        @(posedge clk);
        #1 wr_en = 1'b0;
        #1;
        check("after-edge rd_a", 32'(rd_data_a), 32'h0022);
        @(negedge clk);
        wr_en = 1'b1; clr = 1'b1; wr_data = 16'h0033;
        #1;
        check("clr no bypass", 32'(rd_data_a), 32'h0022);
        @(posedge clk);
        #1 wr_en = 1'b0; clr = 1'b0;
        #1;
        check("clr rd_a", 32'(rd_data_a), 32'h0);
        check("clr dirty", 32'(dirty), 32'h0);

        // Wide configuration, top entry
        @(negedge clk);
        wr_en32 = 1'b1; wr_addr32 = 5'd31; wr_data32 = 32'hFFFF_FFFF;
        rd_addr_a32 = 5'd31; rd_addr_b32 = 5'd0;
        @(posedge clk);
        #1 wr_en32 = 1'b0;
        #1;
        check("w32 rd_a", rd_data_a32, 32'hFFFF_FFFF);
        check("w32 rd_b", rd_data_b32, 32'h0);
        check("w32 dirty", dirty32, 32'h8000_0000);
        check("w32 count", 32'(wr_count32), 32'd1);

        if (sb.size() != 0) check("sb drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
